// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Value of addr[0] that selects each byte lane.
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // Latched request payload (address is carried separately since its width is a parameter).
  typedef struct packed {
    logic              write;
    logic              byte_acc;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 32'd1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data store: synchronous byte-enabled write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = idx_w(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Store contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[idx][7:0]  <= wdata[7:0];
      if (be[1]) mem[idx][15:8] <= wdata[15:8];
    end
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable wait states.
// Optional: define DMEM_MISALIGN_ERR_EN to flag misaligned word and out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned IDX_W  = idx_w(DEPTH_WORDS);
  localparam int unsigned WIDX_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state, state_next;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept_c;
  logic              access_c;
  logic [WIDX_W-1:0] widx_c;
  logic              in_range_c;
  logic              err_c;
  logic              we_c;
  logic [1:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;
  logic [7:0]        lane_c;
  logic [DATA_W-1:0] load_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    access_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept_c   = 1'b1;
          state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = ACCESS;
      end
      ACCESS: begin
        access_c   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address decode and error classification on the latched request.
  assign widx_c     = addr_q[ADDR_W-1:1];
  assign in_range_c = (32'(widx_c) < DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
  assign err_c = (!req_q.byte_acc && addr_q[0]) || !in_range_c;
`else
  assign err_c = 1'b0;
`endif

  assign we_c    = access_c && req_q.write && in_range_c && !err_c;
  assign be_c    = !req_q.byte_acc      ? 2'b11 :
                   (addr_q[0] == LANE_HI) ? 2'b10 : 2'b01;
  assign wdata_c = req_q.byte_acc ? {2{req_q.wdata[7:0]}} : req_q.wdata;
  assign lane_c  = (addr_q[0] == LANE_LO) ? rdata_c[7:0] : rdata_c[15:8];

  always_comb begin
    load_c = '0;
    if (!req_q.write && in_range_c && !err_c)
      load_c = req_q.byte_acc ? {8'h00, lane_c} : rdata_c;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (we_c),
    .be      (be_c),
    .idx     (IDX_W'(widx_c)),
    .wdata   (wdata_c),
    .rdata_c (rdata_c)
  );

  // Registered outputs follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      req_q     <= '0;
      addr_q    <= '0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (accept_c) begin
        req_q  <= '{write: req_write, byte_acc: req_byte, wdata: req_wdata};
        addr_q <= req_addr;
        cnt    <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_c) begin
        rsp_rdata <= load_c;
        rsp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; honours DMEM_MISALIGN_ERR_EN when defined.
module tb_dmem_responder;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DEPTH_WORDS = 256;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int          EXP_LAT     = WAIT_CYCLES + 2;
`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic MERR = 1'b1;
`else
  localparam logic MERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic        wr;
    logic        bt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic bt, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.bt = bt; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One full transaction; lat counts cycles from the accepting cycle to the first rsp_valid cycle.
  task automatic txn(input logic wr, input logic bt, input logic [15:0] addr, input logic [15:0] wdata,
                     output logic [15:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_byte = bt; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          n;

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    add(1, 0, 16'h0000, 16'h1111, 16'h0000, 0);
    add(1, 0, 16'h0010, 16'h1234, 16'h0000, 0);
    add(0, 0, 16'h0010, 16'h0000, 16'h1234, 0);
    add(1, 0, 16'h0020, 16'hABCD, 16'h0000, 0);
    add(1, 1, 16'h0021, 16'hFF55, 16'h0000, 0);
    add(0, 0, 16'h0020, 16'h0000, 16'h55CD, 0);
    add(0, 1, 16'h0020, 16'h0000, 16'h00CD, 0);
    add(0, 1, 16'h0021, 16'h0000, 16'h0055, 0);
    add(1, 1, 16'h0010, 16'h779A, 16'h0000, 0);
    add(0, 0, 16'h0010, 16'h0000, 16'h129A, 0);
    add(0, 0, 16'h0011, 16'h0000, MERR ? 16'h0000 : 16'h129A, MERR);
    add(0, 0, 16'h0200, 16'h0000, 16'h0000, MERR);
    add(1, 0, 16'h0200, 16'hDEAD, 16'h0000, MERR);
    add(0, 1, 16'h0201, 16'h0000, 16'h0000, MERR);
    add(0, 0, 16'h0000, 16'h0000, 16'h1111, 0);
    add(1, 0, 16'h0040, 16'h4444, 16'h0000, 0);
    add(1, 0, 16'h0041, 16'hBEEF, 16'h0000, MERR);
    add(0, 0, 16'h0040, 16'h0000, MERR ? 16'h4444 : 16'hBEEF, 0);
    add(1, 0, 16'h01FE, 16'h0F0F, 16'h0000, 0);
    add(0, 0, 16'h01FE, 16'h0000, 16'h0F0F, 0);
    add(1, 0, 16'h0030, 16'h3333, 16'h0000, 0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst req_ready", 16'(req_ready), 16'h1);
    check("rst rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst rsp_rdata", rsp_rdata, 16'h0000);
    check("rst rsp_err", 16'(rsp_err), 16'h0);
    check("rst busy", 16'(busy), 16'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      txn(vecs[i].wr, vecs[i].bt, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), 16'(er), 16'(vecs[i].exp_err));
      check($sformatf("v%0d latency", i), 16'(lat), 16'(EXP_LAT));
    end

    // Reset during WAIT aborts a store before it commits
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0030; req_wdata = 16'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort busy in wait", 16'(busy), 16'h1);
    check("abort req_ready in wait", 16'(req_ready), 16'h0);
    reset_n = 1'b0;
    #1;
    check("abort rst req_ready", 16'(req_ready), 16'h1);
    check("abort rst rsp_valid", 16'(rsp_valid), 16'h0);
    check("abort rst busy", 16'(busy), 16'h0);
    check("abort rst rsp_rdata", rsp_rdata, 16'h0000);
    check("abort rst rsp_err", 16'(rsp_err), 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    txn(1'b0, 1'b0, 16'h0030, 16'h0000, rd, er, lat);
    check("abort load old data", rd, 16'h3333);
    check("abort load latency", 16'(lat), 16'(EXP_LAT));

    // Response backpressure with a second request held on the request channel
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010; rsp_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 100);
    check("bp latency", 16'(n), 16'(EXP_LAT));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d rsp_valid", k), 16'(rsp_valid), 16'h1);
      check($sformatf("bp hold%0d rsp_rdata", k), rsp_rdata, 16'h129A);
      check($sformatf("bp hold%0d req_ready", k), 16'(req_ready), 16'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp release rsp_valid", 16'(rsp_valid), 16'h0);
    check("bp release req_ready", 16'(req_ready), 16'h1);
    check("bp release busy", 16'(busy), 16'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp reaccept busy", 16'(busy), 16'h1);
    check("bp reaccept req_ready", 16'(req_ready), 16'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp second rdata", rsp_rdata, 16'h129A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp final idle", 16'(busy), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
